mm_loader: RTL and testbench
============================

# mm_loader

Upstream loader for the matrix-multiply engine. Accepts a single valid/ready word stream carrying the three matrix dimensions followed by matrix A and matrix B in row-major order. Writes each word into the operand memory that the multiply engine later reads, using the same (index, i, j) addressing. Raises `load_done` when both operands are resident, so the engine can be released from reset.

## Interface
- `DW`, 20: data word width; matches the engine's `read_data`.
- `AW`, 20: row/column index width; matches the engine's `i`/`j`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `restart`  in  1  synchronous pulse; abandons any load and returns to header capture.
- `in_valid`  in  1  stream word present.
- `in_data`  in  DW  stream word (dimensions unsigned; elements two's complement, passed through unaltered).
- `in_ready`  out  1  loader accepts a word this cycle.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_hdr`  out  1  1 = header write (dimension slot `mem_i`, 0..2); 0 = element write.
- `mem_index`  out  1  0 = matrix A, 1 = matrix B; 0 for header writes.
- `mem_i`, `mem_j`  out  AW  row, column (header: `mem_i` = slot, `mem_j` = 0).
- `mem_wdata`  out  DW  word written.
- `dim_m`, `dim_k`, `dim_n`  out  AW  captured dimensions: A is M×K, B is K×N.
- `load_done`  out  1  both matrices written; held until `restart` or `reset`.
- `error`  out  1  a zero dimension was received; held until `restart` or `reset`.

## Operation
- States: HDR, LOAD_A, LOAD_B, DONE, ERR.
- `in_ready` is combinational: 1 in HDR, LOAD_A and LOAD_B with `restart` low; 0 otherwise.
- A word is accepted on a rising edge with `in_valid` and `in_ready` both high.
- HDR:
  - A header counter (0..2) selects the target: `dim_m`, then `dim_k`, then `dim_n`.
  - Each accepted word also produces a header write.
  - A zero word goes to ERR instead. No write is issued and the dimension register is left unchanged.
  - After slot 2 is accepted: go to LOAD_A with row = col = 0.
- LOAD_A: each accepted word is written to (index 0, row, col).
  - col increments; at col = K-1, col wraps to 0 and row increments.
  - At row = M-1 and col = K-1: go to LOAD_B with row = col = 0.
- LOAD_B: same scan over K×N at index 1.
  - The last element (row = K-1, col = N-1) goes to DONE.
- DONE/ERR: stream is stalled (`in_ready` = 0). Only `restart` or `reset` exits.
- `restart` has priority over everything, including a word presented in the same cycle. That word is not accepted because `in_ready` is already 0.
  - Next state HDR; counters, `load_done` and `error` cleared.
  - Dimension registers keep their values until overwritten.
- Counter compares use AW-bit unsigned arithmetic (`dim - 1`). Zero dimensions never reach a compare, so there is no underflow.

## Timing
- Reset values: `in_ready` 0 while `reset` is asserted, 1 in the first cycle after release (state HDR). All other outputs are 0, and all counters and dimension registers are 0.
- Write latency is 1 cycle. A word accepted at edge t drives `mem_we` = 1 and the registered `mem_*` address/data during cycle t+1 only.
- Back-to-back acceptance gives consecutive `mem_we` cycles. A gap in `in_valid` gives a gap in `mem_we`.
- `load_done` rises in the same cycle as the final B `mem_we`.
- `error` rises in the cycle after the zero word is accepted.
- Reset asserted mid-load: all state is cleared immediately and any pending `mem_we` is killed. The memory contents written so far are not the loader's concern.
- Minimum load time is 3 + M·K + K·N accepted words.

## Structure
- Shared package `mm_pkg` holds:
  - the state encoding (3-bit localparams);
  - `DW`/`AW` defaults;
  - header slot constants `HDR_M` = 0, `HDR_K` = 1, `HDR_N` = 2;
  - the `MAT_A`/`MAT_B` index values.
- Sub-module `rc_counter`: row/column counter with a `limit_rows`/`limit_cols` input, an `inc` enable, a synchronous clear, and a `last` output (row = rows-1 and col = cols-1). It is instantiated once and reused for A and B, with the limits muxed by state.
- Top level (`mm_loader`) contains the FSM, the header counter, the dimension registers and the write-port registers.

## Test plan
- **M=2, K=3, N=2, continuous valid:**
  - stream 2,3,2, then A = 1..6, then B = -1..-6;
  - expect 15 `mem_we`, e.g. A(1,2)=6 and B(2,1)=-6;
  - `load_done` rises with the 15th write; `in_ready` is 0 afterwards.
- **1×1×1:** stream 1,1,1,7,-3 → writes hdr0..2, A(0,0)=7, B(0,0)=-3; `load_done` rises after 5 accepts.
- **Zero dimension:** stream 2,0 → one header write only; `error` = 1 one cycle later; `in_ready` = 0; further words are ignored.
- **Bubbles:** same load as the first scenario, with `in_valid` toggled every other cycle → identical write sequence, and each `mem_we` lands exactly one cycle after its accept.
- **Restart mid-LOAD_A:**
  - assert `restart` after 5 accepts, with `in_valid` high in that same cycle;
  - that word is not accepted and no write follows;
  - the next word lands as header slot 0, and `load_done`/`error` stay 0.
- **Async reset during LOAD_B:** all outputs are 0 immediately; after release, `in_ready` = 1 and the next write is header slot 0.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared constants for the matrix-multiply loader: state encoding, default widths,
// header slot numbers and operand matrix indices.
package mm_pkg;

  localparam int unsigned DEF_DW = 20;
  localparam int unsigned DEF_AW = 20;

  localparam logic [2:0] ST_HDR    = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  localparam logic [1:0] HDR_M = 2'd0;
  localparam logic [1:0] HDR_K = 2'd1;
  localparam logic [1:0] HDR_N = 2'd2;

  localparam logic MAT_A = 1'b0;
  localparam logic MAT_B = 1'b1;

endpackage

// File: rtl/rc_counter.sv
// Row-major row/column scan counter; wraps to (0,0) after the last element so a
// second scan can start immediately with new limits.
module rc_counter #(
  parameter int unsigned AW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic [AW-1:0] limit_rows,
  input  logic [AW-1:0] limit_cols,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last
);

  logic [AW-1:0] row_q, col_q;
  logic          row_end, col_end;

  // Limits are never zero here, so limit - 1 cannot underflow.
  assign row_end = (row_q == limit_rows - AW'(1));
  assign col_end = (col_q == limit_cols - AW'(1));
  assign last    = row_end & col_end;
  assign row     = row_q;
  assign col     = col_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + AW'(1);
      end else begin
        col_q <= col_q + AW'(1);
      end
    end
  end

endmodule

// File: rtl/mm_loader.sv
// Stream loader: captures M/K/N, then writes A (MxK) and B (KxN) row-major into the
// operand memory with one-cycle write latency; flags completion or a zero dimension.
module mm_loader
  import mm_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic          mem_hdr,
  output logic          mem_index,
  output logic [AW-1:0] mem_i,
  output logic [AW-1:0] mem_j,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] dim_m,
  output logic [AW-1:0] dim_k,
  output logic [AW-1:0] dim_n,
  output logic          load_done,
  output logic          error
);

  logic [2:0]    state_q, state_d;
  logic [1:0]    hdr_cnt_q;
  logic [AW-1:0] dim_m_q, dim_k_q, dim_n_q;
  logic          we_q, hdr_q, index_q;
  logic [AW-1:0] i_q, j_q;
  logic [DW-1:0] wdata_q;

  logic          accept, hdr_zero, hdr_take, elem_take;
  logic          cnt_clear, cnt_last;
  logic [AW-1:0] lim_rows, lim_cols, row, col;

  assign accept    = in_valid & in_ready;
  assign hdr_zero  = (in_data == '0);
  assign hdr_take  = accept & (state_q == ST_HDR) & ~hdr_zero;
  assign elem_take = accept & ((state_q == ST_LOAD_A) | (state_q == ST_LOAD_B));
  assign cnt_clear = restart | (state_q == ST_HDR);

  // One counter serves both scans; A is MxK, B is KxN.
  always_comb begin
    lim_rows = dim_m_q;
    lim_cols = dim_k_q;
    if (state_q == ST_LOAD_B) begin
      lim_rows = dim_k_q;
      lim_cols = dim_n_q;
    end
  end

  rc_counter #(.AW(AW)) u_rc_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .inc        (elem_take),
    .limit_rows (lim_rows),
    .limit_cols (lim_cols),
    .row        (row),
    .col        (col),
    .last       (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_HDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HDR: begin
        if (accept) begin
          if (hdr_zero)                state_d = ST_ERR;
          else if (hdr_cnt_q == HDR_N) state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: if (elem_take && cnt_last) state_d = ST_LOAD_B;
      ST_LOAD_B: if (elem_take && cnt_last) state_d = ST_DONE;
      default: ;
    endcase
    if (restart) state_d = ST_HDR;
  end

  always_comb begin
    in_ready  = 1'b0;
    load_done = (state_q == ST_DONE);
    error     = (state_q == ST_ERR);
    unique case (state_q)
      ST_HDR, ST_LOAD_A, ST_LOAD_B: in_ready = ~reset & ~restart;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_cnt_q <= '0;
      dim_m_q   <= '0;
      dim_k_q   <= '0;
      dim_n_q   <= '0;
    end else if (restart) begin
      hdr_cnt_q <= '0;
    end else if (hdr_take) begin
      hdr_cnt_q <= (hdr_cnt_q == HDR_N) ? HDR_M : hdr_cnt_q + 2'd1;
      case (hdr_cnt_q)
        HDR_M:   dim_m_q <= AW'(in_data);
        HDR_K:   dim_k_q <= AW'(in_data);
        default: dim_n_q <= AW'(in_data);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      hdr_q   <= 1'b0;
      index_q <= MAT_A;
      i_q     <= '0;
      j_q     <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= hdr_take | elem_take;
      if (hdr_take) begin
        hdr_q   <= 1'b1;
        index_q <= MAT_A;
        i_q     <= AW'(hdr_cnt_q);
        j_q     <= '0;
        wdata_q <= in_data;
      end else if (elem_take) begin
        hdr_q   <= 1'b0;
        index_q <= (state_q == ST_LOAD_B) ? MAT_B : MAT_A;
        i_q     <= row;
        j_q     <= col;
        wdata_q <= in_data;
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_hdr   = hdr_q;
  assign mem_index = index_q;
  assign mem_i     = i_q;
  assign mem_j     = j_q;
  assign mem_wdata = wdata_q;
  assign dim_m     = dim_m_q;
  assign dim_k     = dim_k_q;
  assign dim_n     = dim_n_q;

endmodule

// File: tb/tb_mm_loader.sv
// Bench for mm_loader: fixed vector table, directed multi-cycle sequences and
// randomized loads checked against a word-count based reference model.
module tb_mm_loader;

  localparam int unsigned DW = 20;
  localparam int unsigned AW = 20;

  typedef logic [DW-1:0] word_q_t[$];

  typedef struct {
    bit          v;
    logic [DW-1:0] d;
    bit          rs;
    bit          rdy;
    bit          we;
    logic [61:0] wr;
    bit          done;
    bit          err;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset, restart, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, mem_we, mem_hdr, mem_index, load_done, error;
  logic [AW-1:0] mem_i, mem_j, dim_m, dim_k, dim_n;
  logic [DW-1:0] mem_wdata;

  mm_loader #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_hdr   (mem_hdr),
    .mem_index (mem_index),
    .mem_i     (mem_i),
    .mem_j     (mem_j),
    .mem_wdata (mem_wdata),
    .dim_m     (dim_m),
    .dim_k     (dim_k),
    .dim_n     (dim_n),
    .load_done (load_done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_writes = 0;

  // Reference model: progress is just the number of accepted words in this load.
  int          nacc;
  bit          merr;
  int unsigned md[3];
  bit          exp_we;
  logic [61:0] exp_wr;  // {hdr, index, i, j, data}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic bit mdone();
    return !merr && nacc >= 3 && (nacc - 3) == int'(md[0] * md[1] + md[1] * md[2]);
  endfunction

  function automatic bit mready(input bit rs);
    return !reset && !rs && !merr && !mdone();
  endfunction

  task automatic model_reset(input bit full);
    nacc   = 0;
    merr   = 0;
    exp_we = 0;
    if (full) md = '{0, 0, 0};
  endtask

  task automatic model_accept(input logic [DW-1:0] w);
    int          e;
    int unsigned mk;
    if (nacc < 3) begin
      if (w == '0) begin
        merr   = 1;
        exp_we = 0;
      end else begin
        md[nacc] = 32'(w);
        exp_wr   = {1'b1, 1'b0, AW'(nacc), AW'(0), w};
        exp_we   = 1;
        nacc++;
      end
    end else begin
      e  = nacc - 3;
      mk = md[0] * md[1];
      if (32'(e) < mk) exp_wr = {1'b0, 1'b0, AW'(32'(e) / md[1]), AW'(32'(e) % md[1]), w};
      else exp_wr = {1'b0, 1'b1, AW'((32'(e) - mk) / md[2]), AW'((32'(e) - mk) % md[2]), w};
      exp_we = 1;
      nacc++;
    end
  endtask

  task automatic check_outputs();
    chk("mem_we", 64'(mem_we), 64'(exp_we));
    if (mem_we) n_writes++;
    if (exp_we) chk("mem_write", 64'({mem_hdr, mem_index, mem_i, mem_j, mem_wdata}), 64'(exp_wr));
    chk("load_done", 64'(load_done), 64'(mdone()));
    chk("error", 64'(error), 64'(merr));
    chk("dims", 64'({dim_m, dim_k, dim_n}), 64'({AW'(md[0]), AW'(md[1]), AW'(md[2])}));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick(input bit v, input logic [DW-1:0] d, input bit rs,
                      output bit acc, output bit rdy_seen);
    bit rdy;
    in_valid = v;
    in_data  = d;
    restart  = rs;
    #1;
    rdy      = mready(rs);
    rdy_seen = in_ready;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    acc = v && rdy;
    if (rs)       model_reset(0);
    else if (acc) model_accept(d);
    else          exp_we = 0;
    @(negedge clk);
    check_outputs();
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid.
  task automatic feed(input word_q_t words, input int mode, input int rs_pct, output bit aborted);
    bit acc, rd, v;
    int cyc;
    aborted = 0;
    cyc     = 0;
    foreach (words[w]) begin
      acc = 0;
      for (int t = 0; t < 50 && !acc; t++) begin
        if (!mready(0)) return;
        v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(99) < 70);
        cyc++;
        if (rs_pct > 0 && $urandom_range(99) < rs_pct) begin
          tick(v, words[w], 1'b1, acc, rd);
          aborted = 1;
          return;
        end
        tick(v, words[w], 1'b0, acc, rd);
      end
      chk("accept_timeout", 64'(acc), 64'(1));
    end
  endtask

  function automatic word_q_t make_load(input int m, input int k, input int n,
                                        input int zs, input bit rnd);
    word_q_t q;
    q.push_back(DW'(m));
    q.push_back(DW'(k));
    q.push_back(DW'(n));
    if (zs >= 0) q[zs] = '0;
    for (int i = 0; i < m * k; i++) q.push_back(rnd ? DW'($urandom) : DW'(i + 1));
    for (int i = 0; i < k * n; i++) q.push_back(rnd ? DW'($urandom) : DW'(-(i + 1)));
    return q;
  endfunction

  vec_t vec[11];

  initial begin
    bit      acc, rd, ab;
    word_q_t q;
    int      zs;

    vec[0]  = '{1, 20'd1,     0, 1, 1, {1'b1, 1'b0, 20'd0, 20'd0, 20'd1},     0, 0};
    vec[1]  = '{1, 20'd1,     0, 1, 1, {1'b1, 1'b0, 20'd1, 20'd0, 20'd1},     0, 0};
    vec[2]  = '{1, 20'd1,     0, 1, 1, {1'b1, 1'b0, 20'd2, 20'd0, 20'd1},     0, 0};
    vec[3]  = '{1, 20'd7,     0, 1, 1, {1'b0, 1'b0, 20'd0, 20'd0, 20'd7},     0, 0};
    vec[4]  = '{1, 20'hFFFFD, 0, 1, 1, {1'b0, 1'b1, 20'd0, 20'd0, 20'hFFFFD}, 1, 0};
    vec[5]  = '{1, 20'd5,     0, 0, 0, 62'd0,                                 1, 0};
    vec[6]  = '{0, 20'd0,     1, 0, 0, 62'd0,                                 0, 0};
    vec[7]  = '{1, 20'd2,     0, 1, 1, {1'b1, 1'b0, 20'd0, 20'd0, 20'd2},     0, 0};
    vec[8]  = '{1, 20'd0,     0, 1, 0, 62'd0,                                 0, 1};
    vec[9]  = '{1, 20'd4,     0, 0, 0, 62'd0,                                 0, 1};
    vec[10] = '{0, 20'd0,     1, 0, 0, 62'd0,                                 0, 0};

    reset    = 1;
    restart  = 0;
    in_valid = 0;
    in_data  = '0;
    model_reset(1);
    @(negedge clk);
    chk("ready_in_reset", 64'(in_ready), 64'(0));
    check_outputs();
    #2 reset = 0;
    @(negedge clk);
    check_outputs();

    // 1x1x1 load, done stall, restart, zero dimension, restart.
    foreach (vec[i]) begin
      tick(vec[i].v, vec[i].d, vec[i].rs, acc, rd);
      chk($sformatf("tbl%0d_ready", i), 64'(rd), 64'(vec[i].rdy));
      chk($sformatf("tbl%0d_we", i), 64'(mem_we), 64'(vec[i].we));
      if (vec[i].we)
        chk($sformatf("tbl%0d_wr", i), 64'({mem_hdr, mem_index, mem_i, mem_j, mem_wdata}),
            64'(vec[i].wr));
      chk($sformatf("tbl%0d_flags", i), 64'({load_done, error}), 64'({vec[i].done, vec[i].err}));
    end

    // 2x3x2 continuous, then bubbles.
    for (int mode = 0; mode < 2; mode++) begin
      q        = make_load(2, 3, 2, -1, 0);
      n_writes = 0;
      feed(q, mode, 0, ab);
      chk($sformatf("writes_mode%0d", mode), 64'(n_writes), 64'(15));
      chk($sformatf("done_mode%0d", mode), 64'(load_done), 64'(1));
      tick(1, 20'h55, 0, acc, rd);
      chk($sformatf("stalled_mode%0d", mode), 64'(rd), 64'(0));
      tick(0, '0, 1, acc, rd);
    end

    // Restart mid-LOAD_A with a word presented in the same cycle.
    q = make_load(2, 3, 2, -1, 0);
    feed(q[0:4], 0, 0, ab);
    tick(1, q[5], 1, acc, rd);
    chk("restart_ready", 64'(rd), 64'(0));
    chk("restart_no_write", 64'(mem_we), 64'(0));
    tick(1, 20'd4, 0, acc, rd);
    chk("restart_hdr0", 64'({mem_we, mem_hdr, mem_i, mem_wdata}), 64'({1'b1, 1'b1, 20'd0, 20'd4}));
    tick(0, '0, 1, acc, rd);

    // Async reset during LOAD_B, with a write pending.
    q = make_load(2, 3, 2, -1, 0);
    feed(q[0:10], 0, 0, ab);
    #2;
    in_valid = 0;
    reset    = 1;
    #1;
    model_reset(1);
    check_outputs();
    chk("ready_async_reset", 64'(in_ready), 64'(0));
    @(negedge clk);
    #2 reset = 0;
    @(negedge clk);
    check_outputs();
    tick(1, 20'd9, 0, acc, rd);
    chk("post_reset_hdr0", 64'({mem_we, mem_hdr, mem_i, mem_wdata}), 64'({1'b1, 1'b1, 20'd0, 20'd9}));
    tick(0, '0, 1, acc, rd);

    // Randomized loads with bubbles, occasional zero dims and restarts.
    for (int r = 0; r < 25; r++) begin
      zs = ($urandom_range(7) == 0) ? int'($urandom_range(2)) : -1;
      q  = make_load(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                     int'($urandom_range(1, 4)), zs, 1);
      feed(q, 2, 2, ab);
      tick(0, '0, 1, acc, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
